seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; next generation of the fixed 3-bit Mealy detectors in the state-machine library.
- Pattern width is generic and the pattern is run-time loadable.
- Adds an input-valid qualifier, a selectable overlapping/non-overlapping mode and a saturating match counter.
- Sits between a serial bit source and a controller or status logic.

Parameters:
- PAT_W, 3, pattern length in bits (legal 2..16).
- PAT_RST, 3'b101, pattern register value after reset (PAT_W bits).
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-low.
- in_valid  input  1  qualifies in; when 0, no state advances.
- in  input  1  serial data bit, newest bit last.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern, MSB = oldest bit.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  pattern-completed strobe (see Behaviour and Optional Feature).
- match_cnt  output  CNT_W  saturating count of matches.
- armed  output  1  history is full; the next valid bit can complete a match.

Behaviour:
- Reset (clr=0, asynchronous): history=0, fill=0, pattern=PAT_RST, match_cnt=0, armed=0, match=0. All remain held while clr=0.
- State:
  - history: PAT_W-1 bit shift register.
  - fill: saturating count 0..PAT_W-1 of valid bits held.
  - pattern register.
- Valid bit, i.e. in_valid=1 and pat_load=0:
  - history <= {history[PAT_W-3:0], in}; for PAT_W=2, history <= in.
  - fill increments, saturating at PAT_W-1.
- hit (combinational) = in_valid & ~pat_load & (fill==PAT_W-1) & ({history,in}==pattern).
- armed = (fill==PAT_W-1).
- On a hit:
  - overlap=1: history and fill update normally, so e.g. 10101 with pattern 101 gives two hits.
  - overlap=0: fill <= 0 at that edge. The next hit needs PAT_W fresh valid bits.
- in_valid=0: history, fill and pattern hold; hit=0. Gaps between valid bits are transparent.
- pat_load=1: pattern <= pat_in; history <= 0; fill <= 0; hit forced 0. The in bit on that cycle is discarded even if in_valid=1.
- match_cnt:
  - Increments by 1 on each hit edge; saturates at 2^CNT_W-1, no wrap.
  - cnt_clr=1 sets it to 0 and wins over a simultaneous hit; the hit still drives match.
  - cnt_clr does not affect history, fill or pattern.
- overlap may change at any cycle; it takes effect at the next hit.
- Latency: a hit on the bit clocked at edge N is counted in match_cnt after edge N.
- Mealy/registered timing of match is set by the Optional Feature.

Optional Feature:
- Macro SEQ_DET_REG_OUT_EN.
- Defined: match is a flop, match <= hit at each rising edge. It is high for exactly one cycle, one cycle after the completing bit, and glitch-free. Reset value is 0.
- Undefined: match = hit combinationally (Mealy). It is high during the cycle in which the completing bit is presented, before the edge, and may glitch with in.
- match_cnt timing is identical in both builds.

Test Plan:
- Reset/defaults: hold clr=0 for 3 cycles, then release; drive valid bits 1,0,1. Required: match_cnt=0 and armed=0 during and immediately after reset; armed=1 after the 2nd valid bit; the 3rd bit produces one match pulse; match_cnt=1.
- Overlap: PAT_RST=101, overlap=1, valid stream 1,0,1,0,1. Required: match on bits 3 and 5; match_cnt=2. Same stream with overlap=0: match on bit 3 only; match_cnt=1.
- Valid gaps and load:
  - Stream 1,0,1 with in_valid=0 for 4 cycles between the 0 and the final 1. Required: exactly one match, on the final bit.
  - Then pat_load=1 with pat_in=011 while in=1 and in_valid=1. Required: no match; armed=0; then the stream 0,1,1 gives match_cnt+1.
- Saturation and clear: CNT_W=2, overlap=1, feed 101010101 (4 hits). Required: match_cnt 1,2,3,3. Then cnt_clr=1 on the same cycle as a hit. Required: match_cnt=0 and match still pulses.
- Async reset mid-stream: assert clr=0 between clock edges after bits 1,0. Required: match_cnt=0 and armed=0 immediately, without waiting for an edge; after release, bit 1 alone gives no match.
- Output timing, run in both builds: single hit on the bit clocked at edge N. Required with SEQ_DET_REG_OUT_EN: match high from edge N to edge N+1. Required without it: match high in the cycle before edge N.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with loadable pattern and match counter
// Define SEQ_DET_REG_OUT_EN to register match (one cycle late, glitch-free); default is Mealy match.
module seq_detector_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int             FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] history;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] window;
  logic             hit;

  // window is the candidate pattern: held history with the live bit appended last
  assign window = {history, in};
  assign armed  = (fill == FILL_MAX);
  assign hit    = in_valid & ~pat_load & armed & (window == pattern);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      history <= '0;
      fill    <= '0;
      pattern <= PAT_RST;
    end else if (pat_load) begin
      pattern <= pat_in;
      history <= '0;
      fill    <= '0;
    end else if (in_valid) begin
      history <= window[PAT_W-2:0];
      // non-overlapping mode discards the bits that formed the match
      if (hit && !overlap) begin
        fill <= '0;
      end else if (!armed) begin
        fill <= fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic match_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
    end
  end

  assign match = match_q;
`else
  assign match = hit;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param (PAT_W=3, CNT_W=2)
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in = 3'b101;
  logic       cnt_clr = 1'b0;
  logic       match;
  logic [1:0] match_cnt;
  logic       armed;

  seq_detector_param #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(2)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m;
    logic a;
    int   c;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_m   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // one entry per cycle: match, armed and count expected before that cycle's edge
  always @(negedge clk) begin : monitor
    exp_t e;
    logic want_m;
    if (q.size() > 0) begin
      e = q.pop_front();
`ifdef SEQ_DET_REG_OUT_EN
      want_m = prev_m;
      prev_m = e.m;
`else
      want_m = e.m;
`endif
      chk("match", {31'd0, match}, {31'd0, want_m});
      chk("armed", {31'd0, armed}, {31'd0, e.a});
      chk("match_cnt", {30'd0, match_cnt}, e.c);
    end
  end

  task automatic step(input logic v, input logic b, input logic ov, input logic ld,
                      input logic cc, input logic em, input logic ea, input int ec);
    exp_t e;
    in_valid = v;
    in       = b;
    overlap  = ov;
    pat_load = ld;
    cnt_clr  = cc;
    e.m = em;
    e.a = ea;
    e.c = ec;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset held for three cycles
    repeat (3) step(0, 0, 1, 0, 0, 0, 0, 0);
    clr = 1'b1;
    // defaults: 1,0,1 with reset pattern 101
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 1);
    pat_in = 3'b101;
    step(0, 0, 1, 1, 1, 0, 1, 1);
    // overlapping 10101 -> two hits
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1, 0, 1, 2);
    // non-overlapping 10101 -> one hit
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1, 0, 1, 1);
    // valid gaps are transparent
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1, 1, 0);
    // load 011 while a valid 1 is presented: bit discarded, history cleared
    pat_in = 3'b011;
    step(1, 1, 1, 1, 0, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1, 1, 1);
    pat_in = 3'b101;
    step(0, 0, 1, 1, 1, 0, 1, 2);
    // saturation with CNT_W=2: 101010101
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0, 1, 1, 1);
    step(1, 0, 1, 0, 0, 0, 1, 2);
    step(1, 1, 1, 0, 0, 1, 1, 2);
    step(1, 0, 1, 0, 0, 0, 1, 3);
    step(1, 1, 1, 0, 0, 1, 1, 3);
    step(0, 0, 1, 0, 0, 0, 1, 3);
    // cnt_clr beats a simultaneous hit, match still pulses
    step(1, 0, 1, 0, 0, 0, 1, 3);
    step(1, 1, 1, 0, 1, 1, 1, 3);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    // async reset mid-stream
    step(0, 0, 1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0, 1, 1);
    clr = 1'b0;
    #1;
    chk("async_cnt", {30'd0, match_cnt}, 0);
    chk("async_armed", {31'd0, armed}, 0);
    chk("async_match", {31'd0, match}, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    clr = 1'b1;
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
